// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default widths for the fetch sequencer
package fetch_pkg;
  localparam int IW = 10;
  localparam int OW = 6;
  localparam int CW = 16;
  localparam logic [CW-1:0] MAX_CNT = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: priority mux for stall/jump/branch/sequential PC update, modulo 2**IW
module next_pc_logic #(
  parameter int IW = fetch_pkg::IW,
  parameter int OW = fetch_pkg::OW
)(
  input  logic [IW-1:0] pc,
  input  logic          stall,
  input  logic          jump_en,
  input  logic [IW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [OW-1:0] branch_offset,
  output logic [IW-1:0] next_pc
);
  logic [IW-1:0] offset_ext;
  assign offset_ext = {{(IW-OW){branch_offset[OW-1]}}, branch_offset};
  // stall beats jump beats branch; sums simply drop the carry out of IW bits
  always_comb begin
    next_pc = stall ? pc : jump_en ? jump_target : branch_taken ? pc + offset_ext : pc + 1'b1;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs the IDLE/RUN/DONE lifecycle and keeps saturating perf counters
module fetch_sequencer #(
  parameter int IW = fetch_pkg::IW,
  parameter int OW = fetch_pkg::OW,
  parameter int CW = fetch_pkg::CW
)(
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          HaltReq,
  input  logic          JumpEn,
  input  logic [IW-1:0] JumpTarget,
  input  logic          BranchTaken,
  input  logic [OW-1:0] BranchOffset,
  output logic [IW-1:0] InstAddress,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount,
  output logic [CW-1:0] InstCount
);
  import fetch_pkg::*;
  state_t state, state_n;
  logic [IW-1:0] pc, pc_n, pc_step;
  logic [CW-1:0] cyc, cyc_n, inst, inst_n;
  next_pc_logic #(.IW(IW), .OW(OW)) u_next_pc (
    .pc(pc),
    .stall(Stall),
    .jump_en(JumpEn),
    .jump_target(JumpTarget),
    .branch_taken(BranchTaken),
    .branch_offset(BranchOffset),
    .next_pc(pc_step)
  );
  // state, PC and counters; reset aborts everything at once
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
      cyc   <= '0;
      inst  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cyc   <= cyc_n;
      inst  <= inst_n;
    end
  end
  // RUN applies halt/next-pc and counts; IDLE and DONE only react to Start
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cyc_n   = cyc;
    inst_n  = inst;
    if (state == RUN) begin
      state_n = HaltReq ? DONE : RUN;
      pc_n    = HaltReq ? pc : pc_step;
      cyc_n   = (&cyc) ? cyc : cyc + 1'b1;
      inst_n  = ((HaltReq || !Stall) && !(&inst)) ? inst + 1'b1 : inst;
    end else if (Start) begin
      state_n = RUN;
      pc_n    = StartAddr;
      cyc_n   = '0;
      inst_n  = '0;
    end
  end
  assign InstAddress = pc;
  assign Running     = (state == RUN);
  assign Done        = (state == DONE);
  assign CycleCount  = cyc;
  assign InstCount   = inst;
endmodule
